// File: rtl/fetch_unit.sv
// IF stage and IF/ID pipeline register of the 5-stage MIPS core: PC, IM address, redirect for beq/j/jal/jr.
// Build option FETCH_FLUSH_ON_TAKEN_EN: squash the wrong-path word on a taken redirect (no delay slot).
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  npc_op,
    input  logic        cmpout,
    input  logic [31:0] rs_val,
    input  logic [31:0] instr_f,
    output logic [31:0] pc_f,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc4_d,
    output logic        valid_d,
    output logic        misalign_f
);

    localparam logic [1:0] NPC_SEQ = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_J   = 2'b10;
    localparam logic [1:0] NPC_JR  = 2'b11;

    logic [31:0] pc_f_q, pc_f_d;
    logic [31:0] instr_d_q, instr_d_d;
    logic [31:0] pc_d_q, pc_d_d;
    logic [31:0] pc4_d_q, pc4_d_d;
    logic        valid_d_q, valid_d_d;

    logic        taken;
    logic [31:0] target;
    logic [31:0] pc_f_plus4;
    logic [31:0] br_off;

    // Redirect is decided from the instruction currently held in ID.
    always_comb begin
        pc_f_plus4 = pc_f_q + 32'd4;
        br_off     = {{14{instr_d_q[15]}}, instr_d_q[15:0], 2'b00};
        taken      = 1'b0;
        target     = pc_f_plus4;
        case (npc_op)
            NPC_BR: begin
                taken  = cmpout;
                target = pc4_d_q + br_off;
            end
            NPC_J: begin
                taken  = 1'b1;
                target = {pc4_d_q[31:28], instr_d_q[25:0], 2'b00};
            end
            NPC_JR: begin
                taken  = 1'b1;
                target = rs_val;
            end
            default: begin
                taken  = 1'b0;
                target = pc_f_plus4;
            end
        endcase
    end

    // A stall freezes everything; the branch stays in ID and is re-evaluated later.
    always_comb begin
        pc_f_d    = pc_f_q;
        instr_d_d = instr_d_q;
        pc_d_d    = pc_d_q;
        pc4_d_d   = pc4_d_q;
        valid_d_d = valid_d_q;
        if (!stall) begin
            pc_f_d    = taken ? target : pc_f_plus4;
            instr_d_d = instr_f;
            pc_d_d    = pc_f_q;
            pc4_d_d   = pc_f_plus4;
            valid_d_d = 1'b1;
`ifdef FETCH_FLUSH_ON_TAKEN_EN
            if (taken) begin
                instr_d_d = NOP_INSTR;
                pc_d_d    = 32'd0;
                pc4_d_d   = 32'd0;
                valid_d_d = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f_q    <= RESET_PC;
            instr_d_q <= NOP_INSTR;
            pc_d_q    <= 32'd0;
            pc4_d_q   <= 32'd0;
            valid_d_q <= 1'b0;
        end else begin
            pc_f_q    <= pc_f_d;
            instr_d_q <= instr_d_d;
            pc_d_q    <= pc_d_d;
            pc4_d_q   <= pc4_d_d;
            valid_d_q <= valid_d_d;
        end
    end

    assign pc_f       = pc_f_q;
    assign instr_d    = instr_d_q;
    assign pc_d       = pc_d_q;
    assign pc4_d      = pc4_d_q;
    assign valid_d    = valid_d_q;
    assign misalign_f = |pc_f_q[1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; expectations hand-derived, honouring FETCH_FLUSH_ON_TAKEN_EN if defined.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset, stall, cmpout;
    logic [1:0]  npc_op;
    logic [31:0] rs_val, instr_f;
    logic [31:0] pc_f, instr_d, pc_d, pc4_d;
    logic        valid_d, misalign_f;

    int n_chk = 0;
    int n_err = 0;

    fetch_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .npc_op(npc_op), .cmpout(cmpout),
        .rs_val(rs_val), .instr_f(instr_f), .pc_f(pc_f), .instr_d(instr_d),
        .pc_d(pc_d), .pc4_d(pc4_d), .valid_d(valid_d), .misalign_f(misalign_f)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset for two edges, then release with the given word on instr_f.
    task automatic do_reset(input logic [31:0] first_word);
        reset = 1'b1; stall = 1'b0; npc_op = 2'b00; cmpout = 1'b0;
        rs_val = 32'd0; instr_f = 32'hDEAD_BEEF;
        tick(); tick();
        reset = 1'b0;
        instr_f = first_word;
    endtask

    initial begin
        // 1: reset values and sequential fetch
        do_reset(32'h1111_0000);
        chk("rst_pc_f", pc_f, 32'h0000_3000);
        chk("rst_instr_d", instr_d, 32'h0);
        chk("rst_pc_d", pc_d, 32'h0);
        chk("rst_pc4_d", pc4_d, 32'h0);
        chk("rst_valid", {31'd0, valid_d}, 32'd0);
        chk("rst_misalign", {31'd0, misalign_f}, 32'd0);
        tick();
        chk("seq1_pc_f", pc_f, 32'h0000_3004);
        chk("seq1_valid", {31'd0, valid_d}, 32'd1);
        chk("seq1_instr_d", instr_d, 32'h1111_0000);
        chk("seq1_pc_d", pc_d, 32'h0000_3000);
        chk("seq1_pc4_d", pc4_d, 32'h0000_3004);
        instr_f = 32'h2222_0000;
        tick();
        chk("seq2_pc_f", pc_f, 32'h0000_3008);

        // 2/5: beq +4 at 3000 taken -> 3014; ID content depends on flush option
        do_reset(32'h1000_0004);
        tick();
        npc_op = 2'b01; cmpout = 1'b1; instr_f = 32'hAAAA_3004;
        tick();
        chk("beq_t_pc_f", pc_f, 32'h0000_3014);
`ifdef FETCH_FLUSH_ON_TAKEN_EN
        chk("beq_t_instr_d", instr_d, 32'h0);
        chk("beq_t_valid", {31'd0, valid_d}, 32'd0);
        chk("beq_t_pc_d", pc_d, 32'h0);
`else
        chk("beq_t_instr_d", instr_d, 32'hAAAA_3004);
        chk("beq_t_valid", {31'd0, valid_d}, 32'd1);
        chk("beq_t_pc_d", pc_d, 32'h0000_3004);
`endif
        // beq not taken -> sequential
        do_reset(32'h1000_0004);
        tick();
        npc_op = 2'b01; cmpout = 1'b0; instr_f = 32'hAAAA_3004;
        tick();
        chk("beq_nt_pc_f", pc_f, 32'h0000_3008);
        chk("beq_nt_instr_d", instr_d, 32'hAAAA_3004);
        chk("beq_nt_valid", {31'd0, valid_d}, 32'd1);

        // 3: beq offset -1 at 3010 -> 3010
        do_reset(32'h0);
        tick(); tick(); tick(); tick();
        chk("walk_pc_f", pc_f, 32'h0000_3010);
        instr_f = 32'h1000_FFFF;
        tick();
        chk("beqm1_pc4_d", pc4_d, 32'h0000_3014);
        npc_op = 2'b01; cmpout = 1'b1; instr_f = 32'h0;
        tick();
        chk("beqm1_pc_f", pc_f, 32'h0000_3010);

        // 3: j 0x0000C40 -> 3100, then back-to-back j
        do_reset(32'h0800_0C40);
        tick();
        npc_op = 2'b10; instr_f = 32'h0800_0C80;
        tick();
        chk("j_pc_f", pc_f, 32'h0000_3100);
        instr_f = 32'h0;
        tick();
`ifdef FETCH_FLUSH_ON_TAKEN_EN
        chk("j2_pc_f", pc_f, 32'h0000_0000);
`else
        chk("j2_pc_f", pc_f, 32'h0000_3200);
`endif

        // 4: jr to misaligned address
        npc_op = 2'b11; rs_val = 32'h0000_3002;
        tick();
        chk("jr_pc_f", pc_f, 32'h0000_3002);
        chk("jr_misalign", {31'd0, misalign_f}, 32'd1);

        // 4: stall with a taken jump holds everything, redirect applied after
        do_reset(32'h0800_0C40);
        tick();
        stall = 1'b1; npc_op = 2'b10; instr_f = 32'hBBBB_BBBB;
        tick();
        chk("stl1_pc_f", pc_f, 32'h0000_3004);
        chk("stl1_instr_d", instr_d, 32'h0800_0C40);
        chk("stl1_pc_d", pc_d, 32'h0000_3000);
        tick();
        chk("stl2_pc_f", pc_f, 32'h0000_3004);
        chk("stl2_instr_d", instr_d, 32'h0800_0C40);
        stall = 1'b0;
        tick();
        chk("stl_rel_pc_f", pc_f, 32'h0000_3100);

        // 6: reset dominates stall and redirect
        reset = 1'b1; stall = 1'b1; npc_op = 2'b10;
        tick();
        chk("rst_dom_pc_f", pc_f, 32'h0000_3000);
        chk("rst_dom_valid", {31'd0, valid_d}, 32'd0);

        // 6: PC wrap FFFF_FFFC -> 0
        reset = 1'b0; stall = 1'b0; npc_op = 2'b11; rs_val = 32'hFFFF_FFFC; instr_f = 32'h0;
        tick();
        chk("wrap_jr_pc_f", pc_f, 32'hFFFF_FFFC);
        npc_op = 2'b00; instr_f = 32'h3333_3333;
        tick();
        chk("wrap_pc_f", pc_f, 32'h0000_0000);
        chk("wrap_pc_d", pc_d, 32'hFFFF_FFFC);
        chk("wrap_pc4_d", pc4_d, 32'h0000_0000);
        chk("wrap_valid", {31'd0, valid_d}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
